// File: rtl/lc4_limb_pkg.sv
// Shared definitions for the limb-serial LC4 ALU: op encodings, FSM states,
// and the limb counter width helper.
package lc4_limb_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDC = 3'b010;
    localparam logic [2:0] OP_TCS  = 3'b011;
    localparam logic [2:0] OP_TCDH = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A one-limb configuration still needs a 1-bit counter to be declarable.
    function automatic int cnt_width(input int nlimb);
        return (nlimb > 1) ? $clog2(nlimb) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(256 / 64);

endpackage

// File: rtl/lc4_limb_adder.sv
// One-limb ripple adder; the carry between limbs is registered in the top.
module lc4_limb_adder #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            cin,
    output logic [LIMB-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};

endmodule

// File: rtl/lc4_limb_alu.sv
// Limb-serial LC4 ALU: processes a WORD_SIZE-bit operation LIMB bits per cycle,
// LSB limb first, with valid/ready handshakes on request and result.
module lc4_limb_alu
    import lc4_limb_pkg::*;
#(
    parameter int WORD_SIZE = 256,
    parameter int LIMB      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_op,
    input  logic [WORD_SIZE-1:0] i_r1data,
    input  logic [WORD_SIZE-1:0] i_r2data,
    input  logic                 i_carry,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] o_result,
    output logic                 o_carry
);

    localparam int NLIMB = WORD_SIZE / LIMB;
    localparam int CNT_W = cnt_width(NLIMB);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 carry_q, carry_d;
    logic [WORD_SIZE-1:0] r1_q, r1_d, r2_q, r2_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 o_carry_q, o_carry_d;
    logic                 o_valid_q, o_valid_d;

    logic [LIMB-1:0] r1_limb, r2_limb, add_a, add_b, add_sum, bw_res, limb_res;
    logic            add_cout, is_bitwise, accept, last_limb;

    lc4_limb_adder #(.LIMB(LIMB)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept     = (state_q == ST_IDLE) && i_valid;
    assign last_limb  = (cnt_q == CNT_W'(NLIMB - 1));
    assign is_bitwise = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_PASS);

    always_comb begin
        r1_limb = '0;
        r2_limb = '0;
        for (int k = 0; k < NLIMB; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                r1_limb = r1_q[k*LIMB +: LIMB];
                r2_limb = r2_q[k*LIMB +: LIMB];
            end
        end

        add_a  = r1_limb;
        add_b  = r2_limb;
        bw_res = r1_limb;
        case (op_q)
            OP_SUB:          add_b = ~r2_limb;
            OP_ADDC:         add_b = '0;
            OP_TCS, OP_TCDH: begin
                add_a = ~r1_limb;
                add_b = '0;
            end
            OP_AND:          bw_res = r1_limb & r2_limb;
            OP_XOR:          bw_res = r1_limb ^ r2_limb;
            default:         ;
        endcase
        limb_res = is_bitwise ? bw_res : add_sum;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        carry_d   = carry_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        result_d  = result_q;
        o_carry_d = o_carry_q;
        o_valid_d = o_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = i_op;
                    r1_d    = i_r1data;
                    r2_d    = i_r2data;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    case (i_op)
                        OP_SUB, OP_TCS:   carry_d = 1'b1;
                        OP_ADDC, OP_TCDH: carry_d = i_carry;
                        default:          carry_d = 1'b0;
                    endcase
                end
            end
            ST_RUN: begin
                for (int k = 0; k < NLIMB; k++) begin
                    if (cnt_q == CNT_W'(k)) result_d[k*LIMB +: LIMB] = limb_res;
                end
                carry_d = is_bitwise ? 1'b0 : add_cout;
                if (last_limb) begin
                    cnt_d     = '0;
                    o_carry_d = is_bitwise ? 1'b0 : add_cout;
                    o_valid_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_ADD;
            carry_q   <= 1'b0;
            result_q  <= '0;
            o_carry_q <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            result_q  <= result_d;
            o_carry_q <= o_carry_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Captured operands are pure data and only change on the accept edge.
    always_ff @(posedge clk) begin
        r1_q <= r1_d;
        r2_q <= r2_d;
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = o_valid_q;
    assign o_result = result_q;
    assign o_carry  = o_carry_q;

endmodule

// File: tb/tb_lc4_limb_alu.sv
// Bench for lc4_limb_alu: a 4-limb and a 1-limb instance, checked against
// a whole-word arithmetic reference model.
module tb_lc4_limb_alu;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv = 1'b0;
    logic         sel = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] r1 = '0, r2 = '0;
    logic         cin = 1'b0;
    logic         i_ready = 1'b0;

    logic         ordy1, ov1, oc1, ordy2, ov2, oc2;
    logic [W-1:0] ores1, ores2;
    logic         ordy, ov, oc;
    logic [W-1:0] ores;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lc4_limb_alu #(.WORD_SIZE(W), .LIMB(64)) dut4 (
        .clk(clk), .rst(rst), .i_valid(iv && !sel), .o_ready(ordy1), .i_op(op),
        .i_r1data(r1), .i_r2data(r2), .i_carry(cin), .o_valid(ov1),
        .i_ready(i_ready), .o_result(ores1), .o_carry(oc1)
    );

    lc4_limb_alu #(.WORD_SIZE(W), .LIMB(256)) dut1 (
        .clk(clk), .rst(rst), .i_valid(iv && sel), .o_ready(ordy2), .i_op(op),
        .i_r1data(r1), .i_r2data(r2), .i_carry(cin), .o_valid(ov2),
        .i_ready(i_ready), .o_result(ores2), .o_carry(oc2)
    );

    assign ordy = sel ? ordy2 : ordy1;
    assign ov   = sel ? ov2   : ov1;
    assign oc   = sel ? oc2   : oc1;
    assign ores = sel ? ores2 : ores1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Whole-word reference: results taken modulo 2^256, carry from the unbounded sum.
    task automatic model(input logic [2:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, output logic [W-1:0] r, output logic co);
        logic [W:0] wide;
        r  = '0;
        co = 1'b0;
        case (mop)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; co = wide[W]; end
            3'd1: begin r = a - b; co = (a >= b); end
            3'd2: begin wide = {1'b0, a} + (W+1)'(c); r = wide[W-1:0]; co = wide[W]; end
            3'd3: begin r = '0 - a; co = (a == '0); end
            3'd4: begin r = c ? ('0 - a) : ~a; co = c && (a == '0); end
            3'd5: r = a & b;
            3'd6: r = a ^ b;
            default: r = a;
        endcase
    endtask

    // Called #1 after the accept edge; the accept edge counts as edge 1.
    task automatic wait_result(input string tag, input logic [W-1:0] er, input logic ec,
                               input bit chk_lat);
        int edges = 1;
        int nl = sel ? 1 : 4;
        while (!ov && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_valid"}, W'(ov), W'(1'b1));
        if (chk_lat) chk({tag, "_lat"}, W'(edges), W'(nl + 1));
        chk({tag, "_res"}, ores, er);
        chk({tag, "_cy"}, W'(oc), W'(ec));
    endtask

    task automatic release_result(input string tag);
        @(negedge clk); i_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drop"}, W'(ov), W'(1'b0));
        chk({tag, "_rdy"}, W'(ordy), W'(1'b1));
        @(negedge clk); i_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] mop, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
        logic [W-1:0] er;
        logic         ec;
        model(mop, a, b, c, er, ec);
        @(negedge clk);
        op = mop; r1 = a; r2 = b; cin = c; iv = 1'b1;
        chk({tag, "_ordy"}, W'(ordy), W'(1'b1));
        @(posedge clk); #1;
        iv = 1'b0;
        r1 = ~a; r2 = ~b; cin = ~c;
        wait_result(tag, er, ec, 1'b1);
        release_result(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er, bp_res;
        logic [2:0]   rop;
        logic         rc, ec, bp_cy;

        #2;
        chk("rst_valid", W'(ov1), W'(1'b0));
        chk("rst_res", ores1, '0);
        chk("rst_cy", W'(oc1), W'(1'b0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ordy", W'(ordy1), W'(1'b1));

        run("add_wrap", 3'd0, '1, W'(1), 1'b0);
        run("sub_5_7", 3'd1, W'(5), W'(7), 1'b0);
        chk("sub_5_7_lit", ores1, {{(W-8){1'b1}}, 8'hFE}); // result held after release
        run("sub_7_7", 3'd1, W'(7), W'(7), 1'b0);
        run("sub_9_0", 3'd1, W'(9), '0, 1'b0);
        run("tcdh_c0", 3'd4, '0, '0, 1'b0);
        run("tcdh_c1", 3'd4, '0, '0, 1'b1);
        run("tcs_1", 3'd3, W'(1), '0, 1'b0);
        run("addc_c1", 3'd2, {W{1'b1}}, '0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rop = 3'(i % 8);
            ra  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (i == 9) rb = ~ra;
            rc  = 1'($urandom);
            run($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rc);
        end

        // Backpressure with a competing request held on the inputs.
        model(3'd1, W'(5), W'(7), 1'b0, bp_res, bp_cy);
        @(negedge clk); op = 3'd1; r1 = W'(5); r2 = W'(7); iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        wait_result("bp", bp_res, bp_cy, 1'b1);
        @(negedge clk); op = 3'd0; r1 = W'(100); r2 = W'(23); cin = 1'b0; iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", i), W'(ov1), W'(1'b1));
            chk($sformatf("bp_hold%0d_ordy", i), W'(ordy1), W'(1'b0));
            chk($sformatf("bp_hold%0d_res", i), ores1, bp_res);
            chk($sformatf("bp_hold%0d_cy", i), W'(oc1), W'(bp_cy));
        end
        @(negedge clk); i_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_valid", W'(ov1), W'(1'b0));
        chk("bp_idle_ordy", W'(ordy1), W'(1'b1));
        @(negedge clk); i_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_accept_ordy", W'(ordy1), W'(1'b0));
        iv = 1'b0;
        wait_result("bp_next", W'(123), 1'b0, 1'b1);
        release_result("bp_next");

        // Reset while limb 2 is being computed.
        @(negedge clk); op = 3'd0; r1 = {W{1'b1}}; r2 = {W{1'b1}}; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", W'(ov1), W'(1'b0));
        chk("midrst_res", ores1, '0);
        chk("midrst_cy", W'(oc1), W'(1'b0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ordy", W'(ordy1), W'(1'b1));
        run("post_rst_add", 3'd0, W'(3), W'(4), 1'b0);

        // Single-limb instance.
        sel = 1'b1;
        run("n1_addc", 3'd2, {W{1'b1}}, '0, 1'b1);
        run("n1_and", 3'd5, {(W/8){8'hF0}}, {{(W/2){1'b1}}, {(W/2){1'b0}}}, 1'b0);
        chk("n1_and_lit", ores2, {{(W/8){4'hF, 4'h0}} & {{(W/2){1'b1}}, {(W/2){1'b0}}}});
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rc  = 1'($urandom);
            run($sformatf("n1_rnd%0d_op%0d", i, rop), rop, ra, rb, rc);
        end
        model(3'd0, W'(1), W'(2), 1'b0, er, ec);
        chk("model_sanity", er, W'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc4_limb_alu.md
Name: lc4_limb_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle wide LC4 ALU datapath for the ECC core.
- Processes a WORD_SIZE-bit operation one LIMB-bit slice per cycle, least-significant limb first, with a registered carry chain. This removes the 256-bit combinational carry path from the critical timing path.
- Sits between the register file read stage and writeback. Uses a valid/ready handshake on both sides, so the pipeline stalls while a multi-limb operation is in flight.

Parameters:
- WORD_SIZE, 256, operand and result width in bits.
- LIMB, 64, bits processed per cycle. LIMB must divide WORD_SIZE.
- NLIMB, WORD_SIZE/LIMB, derived; number of limb cycles per operation.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operation request.
- o_ready  out  1  block can accept a request (high only in IDLE).
- i_op  in  3  operation: 000 ADD, 001 SUB, 010 ADDC, 011 TCS, 100 TCDH, 101 AND, 110 XOR, 111 PASS.
- i_r1data  in  WORD_SIZE  operand A.
- i_r2data  in  WORD_SIZE  operand B.
- i_carry  in  1  carry in, used by ADDC and TCDH.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_result  out  WORD_SIZE  result, registered.
- o_carry  out  1  final carry out, registered.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asynchronous, any state): state goes to IDLE, limb counter to 0, o_result to 0, o_carry to 0, o_valid to 0. o_ready is 1 from the first clock after reset deasserts. An operation in flight is discarded with no partial result exposed.
- IDLE:
  - o_ready=1.
  - On i_valid, capture i_op, i_r1data, i_r2data and i_carry into internal registers; set the carry register to the initial cin; set cnt=0; go to RUN.
  - Operand inputs are sampled only on this accept edge.
- Per-op limb operands (A_k, B_k from the captured operands) and initial cin:
  - ADD: A=r1, B=r2, cin=0.
  - SUB: A=r1, B=~r2, cin=1. o_carry=1 means no borrow, including when r2=0.
  - ADDC: A=r1, B=0, cin=i_carry.
  - TCS: A=~r1, B=0, cin=1.
  - TCDH: A=~r1, B=0, cin=i_carry. Result is the two's complement of r1 if the carry is set, else the one's complement.
  - AND, XOR, PASS: bitwise per limb (PASS returns r1). Carry register is forced to 0, so o_carry=0.
- RUN:
  - Each cycle computes limb cnt as {cout, sum} = A_k + B_k + carry_reg.
  - Writes sum into result bits [cnt*LIMB +: LIMB], updates carry_reg, and increments cnt.
  - When cnt==NLIMB-1: on that edge load o_carry with the final cout, set o_valid=1, go to DONE.
  - Latency: o_valid rises NLIMB+1 clock edges after the accept edge (5 for the defaults).
  - i_valid is ignored in RUN; o_ready=0.
- DONE:
  - o_result and o_carry are stable and o_valid=1 until i_ready is sampled high.
  - On o_valid&&i_ready: o_valid goes to 0 and state goes to IDLE. The next request can be accepted on the following cycle; there is no same-cycle turnaround.
- o_result bits of limbs not yet written during RUN hold their previous value. They are never observable because o_valid=0.
- NLIMB=1 is legal: RUN lasts one cycle, latency 2.
- Reserved op encodings: none; all 8 encodings are defined.

Decomposition:
- Package lc4_limb_pkg:
  - op encoding constants: OP_ADD … OP_PASS;
  - state enum for IDLE/RUN/DONE;
  - counter width constant $clog2(NLIMB) with a minimum of 1.
- Sub-module lc4_limb_adder: combinational, parameter LIMB; inputs a, b, cin; outputs sum and cout. One instance only.
- FSM, limb muxing and result register stay in the top module.

Test Plan (defaults: WORD_SIZE=256, LIMB=64):
- ADD, r1=2^256-1, r2=1 -> o_result=0, o_carry=1, o_valid high exactly 5 edges after accept.
- SUB, r1=5, r2=7 -> o_result=2^256-2 (FF…FE), o_carry=0. SUB, r1=7, r2=7 -> o_result=0, o_carry=1. SUB, r1=9, r2=0 -> o_result=9, o_carry=1.
- TCDH, r1=0, i_carry=0 -> all ones, o_carry=0. TCDH, r1=0, i_carry=1 -> 0, o_carry=1. TCS, r1=1 -> all ones, o_carry=0.
- Backpressure: hold i_ready=0 for 3 cycles after o_valid while driving i_valid=1 with new operands -> o_result, o_carry and o_valid stay stable, o_ready=0, the new request is not accepted. Then i_ready=1 -> IDLE; the request is accepted on the next cycle and produces the correct result.
- Assert rst mid-RUN (cnt=2) -> o_valid, o_result and o_carry go to 0 immediately. o_ready=1 after release; a fresh ADD 3+4 returns 7 with correct latency.
- LIMB=256 (NLIMB=1): ADDC, r1=2^256-1, i_carry=1 -> o_result=0, o_carry=1, latency 2 edges. AND, r1=F0…F0, r2=FF…00 -> F0…00, o_carry=0.
